morse_seq: RTL and testbench
============================

Name: morse_seq

Overview:
- Parametrised Morse-code letter transmitter: the next generation of the board's fixed 8-letter LED sequencer.
- Covers A–Z, uses true unit-based timing (dot/dash/gap), and drives a key output plus per-symbol LEDs.
- Adds one-shot and repeat modes, abort, busy/done/error status.
- Sits between the board switches/keys and the LEDs; the top level wires SW/KEY/LEDR directly.

Parameters:
- UNIT_CYCLES, 25_000_000, CLK cycles per Morse time unit (≥2).
- DASH_UNITS, 3, dash mark length in units.
- GAP_UNITS, 1, space between symbols of one letter, in units.
- LETTER_GAP_UNITS, 3, space between letter repetitions in repeat mode, in units.

Ports:
- CLK  in  1  system clock, rising edge.
- KEY  in  2  KEY[0] = asynchronous active-low reset; KEY[1] = start/abort button, asynchronous, rising edge acts.
- SW  in  6  SW[4:0] = letter code 0..25 (A..Z); SW[5] = repeat mode.
- LEDR  out  4  one-hot current symbol; symbol 0 → LEDR[3], symbol 3 → LEDR[0].
- TONE  out  1  Morse key: high during a mark.
- BUSY  out  1  high while a letter is being sent.
- DONE  out  1  one-cycle pulse on one-shot completion.
- ERR  out  1  sticky: last start had an invalid letter code.

Behaviour:
- Reset: KEY[0] low asynchronously clears every register. LEDR=0, TONE=0, BUSY=0, DONE=0, ERR=0, state IDLE.
- KEY[1] input path:
  - Passes through a 2-flop synchroniser, then a delay flop.
  - rise = sync_q & ~delay_q.
- All outputs are registered and decoded from state (Moore).
- States: IDLE, LOAD, MARK, GAP, LGAP.
- IDLE:
  - rise → LOAD.
  - rise is the only exit from IDLE.
- LOAD (1 cycle):
  - Latches SW[5:0] and looks up {len[2:0], pattern[3:0]} from the package table.
  - pattern is MSB-first; 1 = dash.
  - If code ≥ 26: → IDLE and set ERR.
  - Otherwise: clear ERR, set symbol index = 0, → MARK.
- Start latency: TONE rises after the 4th CLK edge, counting the first edge that samples KEY[1]=1 as edge 1.
- MARK:
  - TONE=1, LEDR = one-hot(index).
  - Duration is UNIT_CYCLES for a dot, DASH_UNITS*UNIT_CYCLES for a dash.
  - Exit when not the last symbol: → GAP.
  - Exit when last symbol and repeat=0: → IDLE, DONE pulses the following cycle.
  - Exit when last symbol and repeat=1: → LGAP.
- GAP:
  - TONE=0, LEDR holds the current index.
  - Lasts GAP_UNITS*UNIT_CYCLES, then index+1 → MARK.
- LGAP:
  - TONE=0, LEDR=0.
  - Lasts LETTER_GAP_UNITS*UNIT_CYCLES, then index=0 → MARK.
  - The latched letter is reused; SW is not re-sampled.
- BUSY = 1 in LOAD, MARK, GAP, LGAP.
- Abort: rise in any state other than IDLE → IDLE next cycle. LEDR/TONE/BUSY clear, no DONE.
- SW changes while BUSY are ignored.
- Timing counters:
  - Prescaler counts 0..UNIT_CYCLES-1 and emits a unit tick at the terminal count.
  - Unit counter counts ticks up to the target.
  - Both are cleared on every state entry, so every timed state is exact in length.
- Counter widths: $clog2 of UNIT_CYCLES and of max(DASH_UNITS, GAP_UNITS, LETTER_GAP_UNITS)+1. No wrap occurs within the legal range.
- Simultaneous events: reset dominates all. Abort dominates timer expiry in the same cycle.

Decomposition:
- Package morse_pkg contains:
  - State enum.
  - LETTER_COUNT = 26, MAX_SYMBOLS = 4.
  - Function morse_lookup(code) → {len, pattern} for A–Z.
- Sub-module morse_unit_timer:
  - Inputs: clear, target_units.
  - Output: expire pulse.
  - Contains the prescaler and the unit counter.

Test Plan (UNIT_CYCLES=4, DASH=3, GAP=1, LGAP=3):
- SW=6'd4 (E), KEY[1] rise → TONE high 4 cycles with LEDR=1000, BUSY 5 cycles incl. LOAD, DONE single pulse, then all zero.
- SW=6'd0 (A) → TONE 4 high / 4 low / 12 high; LEDR=1000 for 8 cycles, then 0100 for 12; DONE once.
- SW=6'b100010 (C, repeat) → TONE marks 12,4,12,4 separated by 4-cycle gaps, 12-cycle LGAP with LEDR=0, pattern repeats; second KEY[1] rise → IDLE next cycle, no DONE.
- SW=6'd27 → no TONE, BUSY only during LOAD, ERR=1 held; following start with SW=6'd4 clears ERR.
- KEY[0] low mid-dash → LEDR/TONE/BUSY=0 with no clock edge; after release, IDLE until a new KEY[1] rise.
- SW=6'd16 (Q, --.-), SW toggled mid-send → marks 12,12,4,12 unaffected; LEDR steps 1000→0100→0010→0001.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared types and the A..Z Morse table for the Morse letter transmitter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package morse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MARK,
    ST_GAP,
    ST_LGAP
  } state_e;

  localparam int LETTER_COUNT = 26;
  localparam int MAX_SYMBOLS  = 4;

  // pattern is left-aligned: symbol i lives in pattern[3-i]; 1 = dash.
  typedef struct packed {
    logic [2:0] len;
    logic [3:0] pattern;
  } morse_sym_t;

  function automatic morse_sym_t morse_lookup(input logic [4:0] code);
    morse_sym_t s;
    case (code)
      5'd0:    s = {3'd2, 4'b0100}; // A .-
      5'd1:    s = {3'd4, 4'b1000}; // B -...
      5'd2:    s = {3'd4, 4'b1010}; // C -.-.
      5'd3:    s = {3'd3, 4'b1000}; // D -..
      5'd4:    s = {3'd1, 4'b0000}; // E .
      5'd5:    s = {3'd4, 4'b0010}; // F ..-.
      5'd6:    s = {3'd3, 4'b1100}; // G --.
      5'd7:    s = {3'd4, 4'b0000}; // H ....
      5'd8:    s = {3'd2, 4'b0000}; // I ..
      5'd9:    s = {3'd4, 4'b0111}; // J .---
      5'd10:   s = {3'd3, 4'b1010}; // K -.-
      5'd11:   s = {3'd4, 4'b0100}; // L .-..
      5'd12:   s = {3'd2, 4'b1100}; // M --
      5'd13:   s = {3'd2, 4'b1000}; // N -.
      5'd14:   s = {3'd3, 4'b1110}; // O ---
      5'd15:   s = {3'd4, 4'b0110}; // P .--.
      5'd16:   s = {3'd4, 4'b1101}; // Q --.-
      5'd17:   s = {3'd3, 4'b0100}; // R .-.
      5'd18:   s = {3'd3, 4'b0000}; // S ...
      5'd19:   s = {3'd1, 4'b1000}; // T -
      5'd20:   s = {3'd3, 4'b0010}; // U ..-
      5'd21:   s = {3'd4, 4'b0001}; // V ...-
      5'd22:   s = {3'd3, 4'b0110}; // W .--
      5'd23:   s = {3'd4, 4'b1001}; // X -..-
      5'd24:   s = {3'd4, 4'b1011}; // Y -.--
      5'd25:   s = {3'd4, 4'b1100}; // Z --..
      default: s = '0;
    endcase
    return s;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Unit-based interval timer: prescaler of UNIT_CYCLES feeding a unit counter.
// Latency: expire_o is combinational, high in the last cycle of target_units_i units after clear.
// Backpressure: none; clear_i restarts both counters on the next edge.
// Ports: clk_i/rst_ni clock and async active-low reset; clear_i restart;
//        target_units_i interval length in units (>=1); expire_o one-cycle end pulse.
module morse_unit_timer #(
  parameter int UNIT_CYCLES = 4,
  parameter int UW          = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic [UW-1:0] target_units_i,
  output logic          expire_o
);

  localparam int PW = $clog2(UNIT_CYCLES);

  logic [PW-1:0] pre_q, pre_d;
  logic [UW-1:0] units_q, units_d;
  logic          tick;

  assign tick     = (pre_q == PW'(UNIT_CYCLES - 1));
  assign expire_o = tick && ((units_q + UW'(1)) == target_units_i);

  // The unit counter restarts on expiry so it never wraps, even while the
  // owning FSM sits in an untimed state and ignores expire_o.
  always_comb begin
    pre_d   = pre_q + PW'(1);
    units_d = units_q;
    if (clear_i) begin
      pre_d   = '0;
      units_d = '0;
    end else if (tick) begin
      pre_d   = '0;
      units_d = expire_o ? '0 : (units_q + UW'(1));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q   <= '0;
      units_q <= '0;
    end else begin
      pre_q   <= pre_d;
      units_q <= units_d;
    end
  end

endmodule

// File: rtl/morse_seq.sv
// Morse letter transmitter A..Z with one-shot/repeat, abort and status outputs.
// Latency: TONE rises after the 4th CLK edge counting the first edge that samples KEY[1]=1.
// Backpressure: none; KEY[1] rises while busy abort, SW is ignored while busy.
// Ports: CLK clock; KEY[0] async active-low reset, KEY[1] start/abort button;
//        SW[4:0] letter, SW[5] repeat; LEDR one-hot symbol; TONE key; BUSY; DONE pulse; ERR sticky.
module morse_seq
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES      = 25_000_000,
  parameter int DASH_UNITS       = 3,
  parameter int GAP_UNITS        = 1,
  parameter int LETTER_GAP_UNITS = 3
) (
  input  logic       CLK,
  input  logic [1:0] KEY,
  input  logic [5:0] SW,
  output logic [3:0] LEDR,
  output logic       TONE,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  localparam int UW = $clog2(max3(DASH_UNITS, GAP_UNITS, LETTER_GAP_UNITS) + 1);

  logic rst_n;
  assign rst_n = KEY[0];

  logic sync1_q, sync2_q, delay_q, rise;
  state_e state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [4:0] code_q, code_d;
  logic rep_q, rep_d, err_q, err_d, done_q, done_d, tone_q, tone_d, busy_q, busy_d;
  logic [3:0] ledr_q, ledr_d;
  logic [UW-1:0] target;
  logic expire, is_last, cur_dash;
  morse_sym_t sym;

  assign rise     = sync2_q & ~delay_q;
  assign sym      = morse_lookup(code_q);
  assign is_last  = ({1'b0, idx_q} == (sym.len - 3'd1));
  assign cur_dash = sym.pattern[2'd3 - idx_q];

  always_comb begin
    target = UW'(1);
    case (state_q)
      ST_MARK: target = cur_dash ? UW'(DASH_UNITS) : UW'(1);
      ST_GAP:  target = UW'(GAP_UNITS);
      ST_LGAP: target = UW'(LETTER_GAP_UNITS);
      default: target = UW'(1);
    endcase
  end

  // Clearing on every state change makes each timed state exactly its length.
  morse_unit_timer #(.UNIT_CYCLES(UNIT_CYCLES), .UW(UW)) u_timer (
    .clk_i          (CLK),
    .rst_ni         (rst_n),
    .clear_i        (state_d != state_q),
    .target_units_i (target),
    .expire_o       (expire)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    code_d  = code_q;
    rep_d   = rep_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: if (rise) begin
        state_d = ST_LOAD;
        code_d  = SW[4:0];
        rep_d   = SW[5];
      end
      ST_LOAD: begin
        if (rise) begin
          state_d = ST_IDLE;
        end else if (code_q >= 5'(LETTER_COUNT)) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          state_d = ST_MARK;
          err_d   = 1'b0;
          idx_d   = 2'd0;
        end
      end
      ST_MARK: begin
        // Abort is tested first so it wins over a coincident expiry.
        if (rise) begin
          state_d = ST_IDLE;
        end else if (expire) begin
          if (!is_last) begin
            state_d = ST_GAP;
          end else if (rep_q) begin
            state_d = ST_LGAP;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (rise) begin
          state_d = ST_IDLE;
        end else if (expire) begin
          state_d = ST_MARK;
          idx_d   = idx_q + 2'd1;
        end
      end
      ST_LGAP: begin
        if (rise) begin
          state_d = ST_IDLE;
        end else if (expire) begin
          state_d = ST_MARK;
          idx_d   = 2'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state itself.
  always_comb begin
    tone_d = (state_d == ST_MARK);
    busy_d = (state_d != ST_IDLE);
    ledr_d = ((state_d == ST_MARK) || (state_d == ST_GAP)) ? (4'b1000 >> idx_d) : 4'b0000;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      delay_q <= 1'b0;
      state_q <= ST_IDLE;
      idx_q   <= '0;
      code_q  <= '0;
      rep_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      tone_q  <= 1'b0;
      busy_q  <= 1'b0;
      ledr_q  <= '0;
    end else begin
      sync1_q <= KEY[1];
      sync2_q <= sync1_q;
      delay_q <= sync2_q;
      state_q <= state_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      rep_q   <= rep_d;
      err_q   <= err_d;
      done_q  <= done_d;
      tone_q  <= tone_d;
      busy_q  <= busy_d;
      ledr_q  <= ledr_d;
    end
  end

  assign LEDR = ledr_q;
  assign TONE = tone_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign ERR  = err_q;

endmodule

// File: tb/tb_morse_seq.sv
module tb_morse_seq;

  localparam int U    = 4;
  localparam int DASH = 3;
  localparam int GAP  = 1;
  localparam int LGAP = 3;

  logic       CLK;
  logic [1:0] KEY;
  logic [5:0] SW;
  logic [3:0] LEDR;
  logic       TONE, BUSY, DONE, ERR;

  morse_seq #(
    .UNIT_CYCLES(U), .DASH_UNITS(DASH), .GAP_UNITS(GAP), .LETTER_GAP_UNITS(LGAP)
  ) dut (
    .CLK(CLK), .KEY(KEY), .SW(SW), .LEDR(LEDR), .TONE(TONE),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       tone;
    logic [3:0] ledr;
    logic       busy;
    logic       done;
    logic       err;
  } obs_t;

  typedef struct {
    logic [5:0] sw;
    int         tone_n;
    int         busy_n;
    int         done_n;
    logic       err;
  } vec_t;

  string morse_tab [0:25] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                              "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                              "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                              "-.--", "--.."};

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   err_m = 1'b0;
  obs_t exp_q[$];
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic obs_t mk(input logic t, input logic [3:0] l, input logic b,
                              input logic d, input logic e);
    obs_t o;
    o.tone = t; o.ledr = l; o.busy = b; o.done = d; o.err = e;
    return o;
  endfunction

  // Reference trace: one entry per cycle, entry 0 is the LOAD cycle.
  task automatic build_exp(input logic [5:0] sw, input int total, input int abort_in,
                           output int abort_out);
    int    code;
    bit    rep;
    string s;
    exp_q.delete();
    code = int'(sw[4:0]);
    rep  = sw[5];
    exp_q.push_back(mk(1'b0, 4'b0, 1'b1, 1'b0, err_m));
    if (code >= 26) begin
      err_m = 1'b1;
    end else begin
      err_m = 1'b0;
      s = morse_tab[code];
      while (exp_q.size() < total) begin
        for (int i = 0; i < s.len(); i++) begin
          int mlen;
          mlen = (s[i] == "-") ? U * DASH : U;
          repeat (mlen) exp_q.push_back(mk(1'b1, 4'b1000 >> i, 1'b1, 1'b0, 1'b0));
          if (i < s.len() - 1)
            repeat (U * GAP) exp_q.push_back(mk(1'b0, 4'b1000 >> i, 1'b1, 1'b0, 1'b0));
        end
        if (!rep) begin
          exp_q.push_back(mk(1'b0, 4'b0, 1'b0, 1'b1, 1'b0));
          break;
        end
        repeat (U * LGAP) exp_q.push_back(mk(1'b0, 4'b0, 1'b1, 1'b0, 1'b0));
      end
    end
    while (exp_q.size() < total) exp_q.push_back(mk(1'b0, 4'b0, 1'b0, 1'b0, err_m));
    while (exp_q.size() > total) void'(exp_q.pop_back());
    abort_out = abort_in;
    if (abort_in >= 0) begin
      if (abort_in + 3 >= total || !exp_q[abort_in + 2].busy) begin
        abort_out = -1;
      end else begin
        for (int k = abort_in + 3; k < total; k++) exp_q[k] = mk(1'b0, 4'b0, 1'b0, 1'b0, err_m);
      end
    end
  endtask

  // Returns right after the edge that moves the DUT into LOAD.
  task automatic press_start();
    @(posedge CLK);
    #1 KEY[1] = 1'b1;
    repeat (2) @(posedge CLK);
    #1 KEY[1] = 1'b0;
    @(posedge CLK);
  endtask

  task automatic run_seq(input logic [5:0] sw, input int total, input int abort_at,
                         input bit toggle, input string tag);
    int   ab;
    obs_t act;
    SW = sw;
    build_exp(sw, total, abort_at, ab);
    press_start();
    for (int k = 0; k < total; k++) begin
      @(negedge CLK);
      act = {TONE, LEDR, BUSY, DONE, ERR};
      chk($sformatf("%s cyc%0d", tag, k), 32'(act), 32'(exp_q[k]));
      if (toggle) SW = 6'($urandom);
      if (ab >= 0 && k == ab) KEY[1] = 1'b1;
      if (ab >= 0 && k == ab + 2) KEY[1] = 1'b0;
    end
  endtask

  task automatic run_count(input vec_t v, input int n);
    int nt, nb, nd;
    nt = 0; nb = 0; nd = 0;
    SW = v.sw;
    press_start();
    for (int k = 0; k < 80; k++) begin
      @(negedge CLK);
      nt += int'(TONE);
      nb += int'(BUSY);
      nd += int'(DONE);
    end
    chk($sformatf("vec%0d tone cycles", n), 32'(nt), 32'(v.tone_n));
    chk($sformatf("vec%0d busy cycles", n), 32'(nb), 32'(v.busy_n));
    chk($sformatf("vec%0d done pulses", n), 32'(nd), 32'(v.done_n));
    chk($sformatf("vec%0d err", n), 32'(ERR), 32'(v.err));
    err_m = (v.sw[4:0] >= 5'd26);
  endtask

  initial begin
    tbl[0] = '{6'd4,  4,  5,  1, 1'b0};  // E
    tbl[1] = '{6'd0,  16, 21, 1, 1'b0};  // A
    tbl[2] = '{6'd27, 0,  1,  0, 1'b1};  // invalid
    tbl[3] = '{6'd4,  4,  5,  1, 1'b0};  // E clears ERR
    tbl[4] = '{6'd16, 40, 53, 1, 1'b0};  // Q
    tbl[5] = '{6'd19, 12, 13, 1, 1'b0};  // T
    tbl[6] = '{6'd26, 0,  1,  0, 1'b1};  // first invalid code
    tbl[7] = '{6'd7,  16, 29, 1, 1'b0};  // H

    SW  = 6'd0;
    KEY = 2'b01;
    #1 KEY = 2'b00;
    #1 chk("reset outputs", 32'({TONE, LEDR, BUSY, DONE, ERR}), 32'd0);
    repeat (3) @(negedge CLK);
    chk("reset held", 32'({TONE, LEDR, BUSY, DONE, ERR}), 32'd0);
    KEY[0] = 1'b1;
    repeat (3) @(negedge CLK);
    chk("idle after reset", 32'({TONE, LEDR, BUSY, DONE, ERR}), 32'd0);

    for (int i = 0; i < 8; i++) run_count(tbl[i], i);

    // C in repeat mode, aborted during the second repetition.
    run_seq(6'b100010, 120, 90, 1'b0, "C repeat");
    // Q with SW scrambled while sending.
    run_seq(6'd16, 70, -1, 1'b1, "Q toggle");

    // Async reset in the middle of A's dash.
    SW = 6'd0;
    press_start();
    repeat (13) @(negedge CLK);
    chk("A dash tone", 32'(TONE), 32'd1);
    #2 KEY[0] = 1'b0;
    #1 chk("async reset mid-dash", 32'({TONE, LEDR, BUSY, DONE, ERR}), 32'd0);
    @(negedge CLK);
    KEY[0] = 1'b1;
    err_m  = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      chk($sformatf("idle after reset cyc%0d", k), 32'({TONE, LEDR, BUSY, DONE, ERR}), 32'd0);
    end
    run_seq(6'd4, 12, -1, 1'b0, "E after reset");

    for (int r = 0; r < 14; r++) begin
      logic [5:0] sw;
      int         ab;
      int         total;
      sw[4:0] = 5'($urandom_range(0, 31));
      sw[5]   = ($urandom_range(0, 2) == 0);
      if (sw[5]) begin
        total = 150;
        ab    = $urandom_range(2, 100);
      end else begin
        total = 70;
        ab    = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 40) : -1;
      end
      run_seq(sw, total, ab, 1'b1, $sformatf("rand%0d sw%0d", r, sw));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
